sd_spi_master: RTL and testbench
================================

# sd_spi_master

Parametrised SPI master for the SD-card port (`sdcs_n`/`sdclk`/`sddo`/`sddi`) of the SD-load FPGA image, replacing the static tie-offs on those pins. It shifts DATA_W-bit words in SPI mode 0 at a runtime-selectable clock rate. A one-deep transmit holding register allows back-to-back words with no idle gap. It is the data path the loader uses to read a configuration image from the card.

## Interface
- DATA_W, 8, bits per transfer word, MSB first; legal range 4..32.
- DIV_W, 8, width of the runtime clock divider input.
- fclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- div  in  DIV_W  half-period of sdclk, in units of (div+1) fclk cycles; sampled when a word is loaded into the shifter.
- cs_en  in  1  1 = assert the card select.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register empty; a transfer is accepted when tx_valid & tx_ready.
- rx_data  out  DATA_W  word received during the last completed transfer; held until the next completion.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  shifter active or holding register full.
- sdcs_n  out  1  card select, active low.
- sdclk  out  1  SPI clock; idles low.
- sddo  out  1  MOSI; idles high.
- sddi  in  1  MISO.

## Operation
- Reset values: tx_ready=1, rx_valid=0, rx_data=0, busy=0, sdcs_n=1, sdclk=0, sddo=1; FSM in IDLE, holding register empty.
- FSM states:
  - IDLE: sdclk=0, sddo=1.
  - LOW: sdclk=0.
  - HIGH: sdclk=1.
- Holding register: tx_ready = ~hold_full. On accept, tx_data is captured and hold_full is set. hold_full clears when the shifter loads the word.
- IDLE with hold_full:
  - load the shifter from the holding register and latch div into div_q;
  - sddo = MSB; bit counter = DATA_W-1; go to LOW.
- LOW: the half-period counter runs from div_q down to 0. On the 0 cycle go to HIGH and sample sddi into the rx shift LSB (rising sclk edge).
- HIGH, counter at 0:
  - If bits remain: shift left, drive the next bit on sddo (falling sclk edge), decrement the bit counter, go to LOW.
  - On the last bit: copy the rx shifter to rx_data and pulse rx_valid. If hold_full, load the next word immediately (same rules as IDLE, including re-latching div) and go to LOW. Otherwise go to IDLE with sddo=1.
- sdcs_n is registered as ~cs_en.
  - Assertion (falling sdcs_n) takes effect at any time.
  - Deassertion is deferred until busy=0, so a word is never cut by CS.
- div changes while busy affect only the next loaded word.
- rx has no backpressure. The consumer must take rx_data on the rx_valid pulse or within the next transfer time.
- Reset mid-transfer aborts the word: no rx_valid, outputs return to reset values.

## Timing
- Accept at edge N. The shifter loads at edge N+1 when IDLE, and busy is high from N+1. The first sdclk rise is (div+1) cycles after the load.
- Word length is 2·DATA_W·(div+1) fclk cycles from load to the rx_valid cycle.
- Back-to-back: the next word's first LOW phase starts in the rx_valid cycle. sdclk shows no gap and each phase stays exactly (div+1) cycles.
- tx_ready returns high the cycle after the shifter loads. Accept and load in the same cycle is allowed: the holding register refills while the shifter drains.
- sddo is stable for at least (div+1) cycles either side of each sdclk rise. The minimum div=0 gives sdclk = fclk/2.

## Structure
- Shared include (alongside the tune include) holds FSM state encodings and DATA_W/DIV_W defaults.
- One sub-module: sd_spi_halfcnt, a DIV_W-bit loadable down-counter with a zero flag, used for the half-period timing.

## Test plan
- Reset, then idle 100 cycles with no stimulus -> sdcs_n=1, sdclk=0, sddo=1, tx_ready=1, busy=0.
- div=3, tx 0xA5, card model returns 0x3C -> 8 sdclk pulses of 4+4 cycles; sddo bits 1,0,1,0,0,1,0,1; rx_valid once at load+64 cycles with rx_data=0x3C.
- div=0, three words 0x00, 0xFF, 0x81 pushed with tx_valid held high -> 24 continuous sdclk periods at fclk/2 and 3 rx_valid pulses spaced 16 cycles apart.
- cs_en dropped to 0 mid-word -> sdcs_n stays 0 until busy falls, then goes to 1 one cycle later.
- div changed from 1 to 7 while a word is shifting -> current word keeps 2-cycle phases; next word uses 8-cycle phases.
- rst_n low for 1 cycle during bit 4 -> immediate return to reset values, no rx_valid, and a following transfer completes correctly.

Source files
------------

// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD-card SPI master: FSM state encodings and the
// default word / divider widths used by the top, its interface and the bench.
package sd_spi_master_pkg;

  localparam int SD_DATA_W = 8;   // bits per transfer word (legal 4..32)
  localparam int SD_DIV_W  = 8;   // width of the runtime half-period divider

  typedef logic [1:0] sd_state_t;

  // IDLE: sdclk=0, sddo=1; LOW: sdclk=0; HIGH: sdclk=1
  localparam sd_state_t ST_IDLE = 2'd0;
  localparam sd_state_t ST_LOW  = 2'd1;
  localparam sd_state_t ST_HIGH = 2'd2;

endpackage

// File: rtl/sd_spi_master_if.sv
// Word-level handshake between the loader and the SPI master.
//   tx_data/tx_valid/tx_ready : transmit word, accepted on tx_valid & tx_ready
//   rx_data/rx_valid          : received word, rx_valid pulses for one cycle
// master modport = the loader side, slave modport = the SPI master.
interface sd_spi_master_if #(
  parameter int DATA_W = sd_spi_master_pkg::SD_DATA_W
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);

endinterface

// File: rtl/sd_spi_halfcnt.sv
// Loadable DIV_W-bit down-counter with a zero flag; times one sdclk half-period.
//   i_fclk, i_rst_n : clock, async active-low reset
//   i_load, i_val   : load i_val (takes priority over counting)
//   o_zero          : counter is at zero (it holds there until reloaded)
module sd_spi_halfcnt #(
  parameter int DIV_W = 8
) (
  input  logic             i_fclk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_val,
  output logic             o_zero
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 master for the SD-card port. Shifts DATA_W-bit words MSB first,
// half-period of (i_div+1) fclk cycles latched per word, one-deep tx holding
// register so consecutive words run with no sdclk gap.
//   i_fclk, i_rst_n : clock, async active-low reset
//   i_div           : sdclk half-period - 1, sampled when a word loads
//   i_cs_en         : request card select; release waits for o_busy=0
//   bus (slave)     : tx/rx word handshake
//   o_busy          : shifter active or holding register full
//   o_sdcs_n, o_sdclk, o_sddo, i_sddi : SD-card SPI pins
module sd_spi_master
  import sd_spi_master_pkg::*;
#(
  parameter int DATA_W = SD_DATA_W,
  parameter int DIV_W  = SD_DIV_W
) (
  input  logic             i_fclk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_cs_en,
  sd_spi_master_if.slave   bus,
  output logic             o_busy,
  output logic             o_sdcs_n,
  output logic             o_sdclk,
  output logic             o_sddo,
  input  logic             i_sddi
);

  localparam int BCW = $clog2(DATA_W);

  sd_state_t         r_state;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_tx_sh;     // MSB is the live sddo bit; idles all-ones
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_sdclk;
  logic              r_sdcs_n;
  logic [DIV_W-1:0]  r_div_q;
  logic [BCW-1:0]    r_bitcnt;

  logic              w_accept;
  logic              w_zero;
  logic              w_last;
  logic              w_phase_end;
  logic              w_load_shift;
  logic              w_cnt_load;
  logic [DIV_W-1:0]  w_cnt_val;
  logic              w_busy;

  assign w_accept    = bus.tx_valid & ~r_hold_full;
  assign w_last      = (r_bitcnt == '0);
  assign w_phase_end = (r_state != ST_IDLE) & w_zero;
  // Load from IDLE, or straight out of the final HIGH phase for back-to-back.
  assign w_load_shift = r_hold_full &
                        ((r_state == ST_IDLE) | ((r_state == ST_HIGH) & w_zero & w_last));
  assign w_cnt_load  = w_phase_end | w_load_shift;
  // A fresh word takes the live divider; div_q is only valid from the next cycle.
  assign w_cnt_val   = w_load_shift ? i_div : r_div_q;
  assign w_busy      = (r_state != ST_IDLE) | r_hold_full;

  sd_spi_halfcnt #(.DIV_W(DIV_W)) u_halfcnt (
    .i_fclk  (i_fclk),
    .i_rst_n (i_rst_n),
    .i_load  (w_cnt_load),
    .i_val   (w_cnt_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_full <= 1'b0;
      r_hold      <= '0;
    end else begin
      if (w_accept) r_hold <= bus.tx_data;
      r_hold_full <= w_accept | (r_hold_full & ~w_load_shift);
    end
  end

  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_sdclk    <= 1'b0;
      r_tx_sh    <= '1;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_div_q    <= '0;
      r_bitcnt   <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_LOW: if (w_zero) begin
          // rising sdclk: sample MISO
          r_state <= ST_HIGH;
          r_sdclk <= 1'b1;
          r_rx_sh <= {r_rx_sh[DATA_W-2:0], i_sddi};
        end
        ST_HIGH: if (w_zero) begin
          // falling sdclk: advance MOSI or finish the word
          r_sdclk <= 1'b0;
          if (!w_last) begin
            r_tx_sh  <= {r_tx_sh[DATA_W-2:0], 1'b1};
            r_bitcnt <= r_bitcnt - 1'b1;
            r_state  <= ST_LOW;
          end else begin
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
            r_tx_sh    <= '1;
            r_state    <= ST_IDLE;
          end
        end
        default: ;
      endcase
      // overrides the IDLE return above when a word is waiting
      if (w_load_shift) begin
        r_tx_sh  <= r_hold;
        r_div_q  <= i_div;
        r_bitcnt <= BCW'(DATA_W - 1);
        r_state  <= ST_LOW;
        r_sdclk  <= 1'b0;
      end
    end
  end

  // Select asserts immediately; release is held off until the word drains.
  always_ff @(posedge i_fclk or negedge i_rst_n) begin
    if (!i_rst_n)      r_sdcs_n <= 1'b1;
    else if (i_cs_en)  r_sdcs_n <= 1'b0;
    else if (!w_busy)  r_sdcs_n <= 1'b1;
  end

  assign bus.tx_ready = ~r_hold_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign o_busy       = w_busy;
  assign o_sdcs_n     = r_sdcs_n;
  assign o_sdclk      = r_sdclk;
  assign o_sddo       = r_tx_sh[DATA_W-1];

endmodule

// File: tb/tb_sd_spi_master.sv
module tb_sd_spi_master;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] div = '0;
  logic       cs_en = 1'b0;
  logic       busy, sdcs_n, sdclk, sddo;
  logic       sddi = 1'b1;

  sd_spi_master_if #(.DATA_W(W)) bus ();

  sd_spi_master #(.DATA_W(W), .DIV_W(8)) dut (
    .i_fclk(clk), .i_rst_n(rst_n), .i_div(div), .i_cs_en(cs_en), .bus(bus),
    .o_busy(busy), .o_sdcs_n(sdcs_n), .o_sdclk(sdclk), .o_sddo(sddo), .i_sddi(sddi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: per accepted word the expected MOSI word, card reply and half-period
  typedef struct { logic [7:0] tx; logic [7:0] rx; int d; } exp_t;
  exp_t exp_q[$];
  bit   card_bits[$];   // card MISO bit stream, one bit consumed per sdclk fall
  int   rxv_q[$];       // cycle of each rx_valid
  int   rise_q[$];      // cycle of each sdclk rise
  int   cyc = 0;

  always @(posedge clk) cyc++;

  // word monitor, sampled on the falling fclk edge
  int       nb = 0, last_rise = 0, last_chg = -1000, md = 0;
  bit       perr = 0;
  logic     p_sdclk = 1'b0, p_sddo = 1'b1;
  logic [7:0] bits = '0;
  exp_t     e;

  always @(negedge clk) begin
    md = (exp_q.size() > 0) ? exp_q[0].d : 0;
    if (!rst_n) begin
      nb = 0; perr = 0; p_sdclk = 1'b0; p_sddo = 1'b1; last_chg = -1000; sddi = 1'b1;
    end else begin
      if (sddo !== p_sddo) begin
        if (sdclk) perr = 1;          // MOSI must hold through the high phase
        last_chg = cyc;
      end
      if (sdclk && !p_sdclk) begin
        if (exp_q.size() == 0) perr = 1;
        if (nb > 0 && cyc - last_rise != 2 * (md + 1)) perr = 1;
        if (cyc - last_chg < md + 1) perr = 1;  // setup before rise
        bits = {bits[6:0], sddo};
        last_rise = cyc;
        nb++;
        rise_q.push_back(cyc);
      end
      if (!sdclk && p_sdclk) begin
        if (cyc - last_rise != md + 1) perr = 1;
        if (card_bits.size() > 0) void'(card_bits.pop_front());
      end
      if (bus.rx_valid) begin
        chk("rx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sddo_word", bits, e.tx);
          chk("rx_data", bus.rx_data, e.rx);
          chk("nbits", nb, W);
          chk("phase_timing", perr, 0);
          chk("rxv_after_last_rise", cyc - last_rise, e.d + 1);
        end
        rxv_q.push_back(cyc);
        nb = 0; perr = 0;
      end
      sddi = (card_bits.size() > 0) ? card_bits[0] : 1'b1;
      p_sdclk = sdclk; p_sddo = sddo;
    end
  end

  // present a word from a falling edge; returns one falling edge after acceptance
  task automatic send(input logic [7:0] tx, input logic [7:0] rx, input int d, output int acc);
    int n = 0;
    bus.tx_data = tx; bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 2000) begin @(negedge clk); n++; end
    chk("tx_accept_timeout", n < 2000, 1);
    exp_q.push_back('{tx, rx, d});
    for (int i = 7; i >= 0; i--) card_bits.push_back(rx[i]);
    acc = cyc + 1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rxv_q.size() < n && t < 5000) begin @(negedge clk); t++; end
    chk("rx_wait_timeout", rxv_q.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    chk("idle_wait_timeout", busy, 0);
  endtask

  initial begin
    int a, a2, base, bad, flag, t, nexp;
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // T1: idle after reset
    repeat (100) @(negedge clk);
    chk("t1_sdcs_n", sdcs_n, 1);
    chk("t1_sdclk", sdclk, 0);
    chk("t1_sddo", sddo, 1);
    chk("t1_tx_ready", bus.tx_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_rx_valid_cnt", rxv_q.size(), 0);
    chk("t1_rx_data", bus.rx_data, 0);

    // T2: single word, div=3
    div = 8'd3; cs_en = 1'b1;
    rise_q.delete();
    send(8'hA5, 8'h3C, 3, a);
    chk("t2_tx_ready_full", bus.tx_ready, 0);
    @(negedge clk);
    chk("t2_tx_ready_back", bus.tx_ready, 1);
    chk("t2_busy", busy, 1);
    chk("t2_sdcs_n", sdcs_n, 0);
    wait_rx(1);
    chk("t2_rxv_latency", rxv_q[0] - a, 65);
    chk("t2_first_rise", rise_q[0] - a, 5);
    chk("t2_nrise", rise_q.size(), 8);

    // T3: three words back-to-back at div=0
    div = 8'd0;
    rise_q.delete();
    base = rxv_q.size();
    send(8'h00, 8'($urandom), 0, a);
    send(8'hFF, 8'($urandom), 0, a2);
    send(8'h81, 8'($urandom), 0, a2);
    wait_rx(base + 3);
    chk("t3_rx_spacing0", rxv_q[base+1] - rxv_q[base], 16);
    chk("t3_rx_spacing1", rxv_q[base+2] - rxv_q[base+1], 16);
    chk("t3_nrise", rise_q.size(), 24);
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 2) bad++;
    chk("t3_sdclk_gaps", bad, 0);

    // T4: CS release deferred to end of word
    div = 8'd2;
    base = rxv_q.size();
    send(8'($urandom), 8'($urandom), 2, a);
    repeat (10) @(negedge clk);
    cs_en = 1'b0;
    flag = 0; t = 0;
    while (busy && t < 2000) begin
      if (sdcs_n !== 1'b0) flag = 1;
      @(negedge clk); t++;
    end
    chk("t4_cs_held", flag, 0);
    chk("t4_cs_at_busy_fall", sdcs_n, 0);
    @(negedge clk);
    chk("t4_cs_release", sdcs_n, 1);
    chk("t4_rx_count", rxv_q.size(), base + 1);
    cs_en = 1'b1;
    @(negedge clk);
    chk("t4_cs_assert", sdcs_n, 0);

    // T5: div change mid-word only affects the next word
    div = 8'd1;
    base = rxv_q.size();
    send(8'($urandom), 8'($urandom), 1, a);
    send(8'($urandom), 8'($urandom), 7, a2);
    div = 8'd7;
    wait_rx(base + 2);
    chk("t5_second_word_len", rxv_q[base+1] - rxv_q[base], 128);

    // T6: reset during bit 4 aborts the word
    wait_idle();
    div = 8'd1;
    base = rise_q.size();
    send(8'($urandom), 8'($urandom), 1, a);
    t = 0;
    while (rise_q.size() < base + 4 && t < 2000) begin @(negedge clk); t++; end
    chk("t6_reach_bit4", rise_q.size() >= base + 4, 1);
    rst_n = 1'b0;
    exp_q.delete(); card_bits.delete();
    base = rxv_q.size();
    #1;
    chk("t6_sdclk", sdclk, 0);
    chk("t6_sddo", sddo, 1);
    chk("t6_sdcs_n", sdcs_n, 1);
    chk("t6_tx_ready", bus.tx_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_rx_data", bus.rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_rx_valid", rxv_q.size(), base);
    send(8'h5A, 8'hC3, 1, a);
    wait_rx(base + 1);

    // random words, divider varied between bursts
    nexp = rxv_q.size();
    for (int g = 0; g < 4; g++) begin
      wait_idle();
      div = 8'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(8'($urandom), 8'($urandom), int'(div), a);
        nexp++;
      end
    end
    wait_rx(nexp);
    chk("exp_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
